// File: rtl/subtractor_64bit_seq.sv
// rtl/subtractor_64bit_seq.sv - digit-serial 64-bit subtractor, a + ~b + 1 over DIGIT_W-bit slices
// Optional SUB_OVF_EN adds the signed-overflow output ovf.
module subtractor_64bit_seq #(
  parameter int DIGIT_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] diff,
  output logic        borrow
`ifdef SUB_OVF_EN
  ,
  output logic        ovf
`endif
);

  localparam int NSLICE = 64 / DIGIT_W;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t       state;
  logic [63:0]  a_sh;
  logic [63:0]  b_sh;
  logic [63:0]  res;
  logic         carry;
  logic [6:0]   cnt;
  logic         brw;
  logic [DIGIT_W:0] slice;
  logic [63:0]  a_nxt;
  logic [63:0]  b_nxt;
  logic [63:0]  res_nxt;
  logic         last;

`ifdef SUB_OVF_EN
  logic a_msb;
  logic b_msb;
  logic ovf_r;
  assign ovf = ovf_r;
`endif

  assign slice = {1'b0, a_sh[DIGIT_W-1:0]} + {1'b0, b_sh[DIGIT_W-1:0]}
               + (DIGIT_W+1)'(carry);
  assign last  = (cnt == 7'(NSLICE - 1));

  // Full-width digit collapses to a single combinational add; no shifting needed.
  generate
    if (DIGIT_W == 64) begin : g_full
      assign a_nxt   = '0;
      assign b_nxt   = '0;
      assign res_nxt = slice[63:0];
    end else begin : g_part
      assign a_nxt   = {{DIGIT_W{1'b0}}, a_sh[63:DIGIT_W]};
      assign b_nxt   = {{DIGIT_W{1'b0}}, b_sh[63:DIGIT_W]};
      assign res_nxt = {slice[DIGIT_W-1:0], res[63:DIGIT_W]};
    end
  endgenerate

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);
  assign diff      = res;
  assign borrow    = brw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      brw   <= 1'b0;
`ifdef SUB_OVF_EN
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf_r <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= ~b;
            carry <= 1'b1;
            cnt   <= '0;
            state <= RUN;
`ifdef SUB_OVF_EN
            a_msb <= a[63];
            b_msb <= b[63];
`endif
          end
        end
        RUN: begin
          a_sh  <= a_nxt;
          b_sh  <= b_nxt;
          res   <= res_nxt;
          carry <= slice[DIGIT_W];
          cnt   <= cnt + 7'd1;
          if (last) begin
            state <= HOLD;
            brw   <= ~slice[DIGIT_W];
`ifdef SUB_OVF_EN
            // Top slice bit is diff[63] on the final step.
            ovf_r <= (a_msb != b_msb) && (slice[DIGIT_W-1] != a_msb);
`endif
          end
        end
        HOLD: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_subtractor_64bit_seq.sv
// tb/tb_subtractor_64bit_seq.sv - directed bench for subtractor_64bit_seq (DIGIT_W 4, 1, 64)
module tb_subtractor_64bit_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, borrow;
  logic [63:0] a, b, diff;

  logic        w_valid, w_out_ready;
  logic [63:0] w_a, w_b;
  logic        w1_ready, w1_valid, w1_borrow;
  logic        w64_ready, w64_valid, w64_borrow;
  logic [63:0] w1_diff, w64_diff;

`ifdef SUB_OVF_EN
  logic ovf, w1_ovf, w64_ovf;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  subtractor_64bit_seq #(.DIGIT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow(borrow)
`ifdef SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  subtractor_64bit_seq #(.DIGIT_W(1)) dut_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(w_valid), .in_ready(w1_ready),
    .a(w_a), .b(w_b), .out_valid(w1_valid), .out_ready(w_out_ready),
    .diff(w1_diff), .borrow(w1_borrow)
`ifdef SUB_OVF_EN
    , .ovf(w1_ovf)
`endif
  );

  subtractor_64bit_seq #(.DIGIT_W(64)) dut_w64 (
    .clk(clk), .rst_n(rst_n), .in_valid(w_valid), .in_ready(w64_ready),
    .a(w_a), .b(w_b), .out_valid(w64_valid), .out_ready(w_out_ready),
    .diff(w64_diff), .borrow(w64_borrow)
`ifdef SUB_OVF_EN
    , .ovf(w64_ovf)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic start_op(input logic [63:0] x, input logic [63:0] y);
    in_valid = 1'b1;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = ~x;
    b = ~y;
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int n = 0;
    bit rdy_low = 1'b1;
    while (!out_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (in_ready) rdy_low = 1'b0;
    end
    check({tag, "_lat"}, 64'(n), 64'(exp_lat));
    check({tag, "_rdy_low"}, 64'(rdy_low), 64'd1);
  endtask

  task automatic accept(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_ovalid_drop"}, 64'(out_valid), 64'd0);
    check({tag, "_iready_back"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    bit stable;
    int n;
    int lat1, lat64;
    logic [63:0] d1, d64;
    logic bw1, bw64;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    w_valid = 1'b0; w_out_ready = 1'b1; w_a = '0; w_b = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_diff", diff, 64'd0);
    check("rst_borrow", 64'(borrow), 64'd0);
`ifdef SUB_OVF_EN
    check("rst_ovf", 64'(ovf), 64'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    start_op(64'd5, 64'd3);
    wait_done("t5m3", 16);
    check("t5m3_diff", diff, 64'd2);
    check("t5m3_borrow", 64'(borrow), 64'd0);
`ifdef SUB_OVF_EN
    check("t5m3_ovf", 64'(ovf), 64'd0);
`endif
    accept("t5m3");

    start_op(64'd0, 64'd1);
    wait_done("t0m1", 16);
    check("t0m1_diff", diff, 64'hFFFF_FFFF_FFFF_FFFF);
    check("t0m1_borrow", 64'(borrow), 64'd1);
`ifdef SUB_OVF_EN
    check("t0m1_ovf", 64'(ovf), 64'd0);
`endif
    accept("t0m1");

    start_op(64'h8000_0000_0000_0000, 64'd1);
    wait_done("tmin", 16);
    check("tmin_diff", diff, 64'h7FFF_FFFF_FFFF_FFFF);
    check("tmin_borrow", 64'(borrow), 64'd0);
`ifdef SUB_OVF_EN
    check("tmin_ovf", 64'(ovf), 64'd1);
`endif
    accept("tmin");

    // Stall in HOLD while new operands are offered.
    start_op(64'd10, 64'd3);
    wait_done("hold", 16);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      @(posedge clk);
      #1;
      if (diff !== 64'd7 || borrow !== 1'b0 || !out_valid || in_ready) stable = 1'b0;
    end
    check("hold_stable", 64'(stable), 64'd1);
    in_valid = 1'b0;
    accept("hold");
    start_op(64'd50, 64'd8);
    check("hold_next_accepted", 64'(in_ready), 64'd0);
    wait_done("next", 16);
    check("next_diff", diff, 64'd42);
    accept("next");

    // Asynchronous reset partway through RUN.
    start_op(64'd7, 64'd2);
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_diff", diff, 64'd0);
    check("mid_rst_borrow", 64'(borrow), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_op(64'd100, 64'd58);
    wait_done("post_rst", 16);
    check("post_rst_diff", diff, 64'd42);
    check("post_rst_borrow", 64'(borrow), 64'd0);
    accept("post_rst");

    // Extreme digit widths run side by side.
    @(negedge clk);
    w_valid = 1'b1;
    w_a = 64'h1234_5678_9ABC_DEF0;
    w_b = 64'h0FED_CBA9_8765_4321;
    @(posedge clk);
    #1;
    w_valid = 1'b0;
    w_a = '0;
    w_b = '0;
    lat1 = -1; lat64 = -1; d1 = '0; d64 = '0; bw1 = 1'b1; bw64 = 1'b1;
    n = 0;
    while ((lat1 < 0 || lat64 < 0) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (w1_valid && lat1 < 0) begin lat1 = n; d1 = w1_diff; bw1 = w1_borrow; end
      if (w64_valid && lat64 < 0) begin lat64 = n; d64 = w64_diff; bw64 = w64_borrow; end
    end
    check("w1_lat", 64'(lat1), 64'd64);
    check("w1_diff", d1, 64'h0246_8ACF_1357_9BCF);
    check("w1_borrow", 64'(bw1), 64'd0);
    check("w64_lat", 64'(lat64), 64'd1);
    check("w64_diff", d64, 64'h0246_8ACF_1357_9BCF);
    check("w64_borrow", 64'(bw64), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
